// File: rtl/instmem_boot.sv
// Instruction memory with a self-loading boot image: after reset an init FSM writes the boot
// program, zero-fills the rest, then serves single-port reads/writes. Optional macro: INSTMEM_PARITY_EN.
module instmem_boot #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,
  parameter int BOOT_LEN = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reload,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err,
  output logic              par_err
);

  localparam int IC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INSTMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_CLEAR, S_READY} state_t;

  state_t            state_q, state_d;
  logic [IC_W-1:0]   ic_q, ic_d;
  logic [DATA_W-1:0] dataout_q;
  logic              rd_valid_q, addr_err_q;

  logic [MEM_W-1:0]  mem [DEPTH];

  logic              ready, in_range, rd_ok;
  logic [IC_W-1:0]   aidx;
  logic [MEM_W-1:0]  rd_word;
  logic              mem_we;
  logic [IC_W-1:0]   mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  function automatic logic [DATA_W-1:0] boot_word(input logic [IC_W-1:0] i);
    logic [31:0] w;
    case (int'(i))
      0:       w = 32'h0842_1000;
      1:       w = 32'h8214_0000;
      2:       w = 32'h4BE1_1900;
      3:       w = 32'h8A14_0004;
      4:       w = 32'h8A14_0004;
      5:       w = 32'h2FFC_0014;
      default: w = 32'h0000_0000;
    endcase
    return DATA_W'(w);
  endfunction

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef INSTMEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign ready    = (state_q == S_READY);
  assign in_range = ({1'b0, addr} < DEPTH_X);
  assign aidx     = addr[IC_W-1:0];
  assign rd_ok    = ready & rd_en & in_range;
  assign rd_word  = mem[aidx];

  always_comb begin
    state_d   = state_q;
    ic_d      = ic_q;
    mem_we    = 1'b0;
    mem_waddr = ic_q;
    mem_wdata = '0;
    case (state_q)
      S_BOOT: begin
        mem_we    = 1'b1;
        mem_wdata = boot_word(ic_q);
        if (ic_q == IC_W'(BOOT_LEN - 1)) begin
          if (BOOT_LEN < DEPTH) begin
            state_d = S_CLEAR;
            ic_d    = ic_q + 1'b1;
          end else begin
            state_d = S_READY;
          end
        end else begin
          ic_d = ic_q + 1'b1;
        end
      end
      S_CLEAR: begin
        mem_we = 1'b1;
        // Terminal compare instead of letting ic wrap past the last word.
        if (ic_q == IC_W'(DEPTH - 1)) state_d = S_READY;
        else                          ic_d    = ic_q + 1'b1;
      end
      S_READY: begin
        mem_we    = wr_en & in_range;
        mem_waddr = aidx;
        mem_wdata = datain;
        if (reload) begin
          state_d = S_BOOT;
          ic_d    = '0;
        end
      end
      default: begin
        state_d = S_BOOT;
        ic_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_BOOT;
      ic_q       <= '0;
      dataout_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ic_q       <= ic_d;
      rd_valid_q <= rd_ok;
      addr_err_q <= ready & (rd_en | wr_en) & ~in_range;
      if (rd_ok) dataout_q <= rd_word[DATA_W-1:0];
    end
  end

  // Array is deliberately unreset; a read in the same cycle as a write sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= encode(mem_wdata);
  end

`ifdef INSTMEM_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par_err_q <= 1'b0;
    else          par_err_q <= rd_ok & (rd_word[DATA_W] != ^rd_word[DATA_W-1:0]);
  end

  assign par_err = par_err_q;

  task automatic flip_parity(input logic [ADDR_W-1:0] a);
    mem[a[IC_W-1:0]][DATA_W] <= ~mem[a[IC_W-1:0]][DATA_W];
  endtask
`else
  assign par_err = 1'b0;
`endif

  assign dataout  = dataout_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q != S_READY);
  assign addr_err = addr_err_q;

endmodule
